out_bram_reader: RTL and testbench

//  Responder side of the filter control FSM's start/index/idle handshake for the output stage.
//  On a start pulse it latches the ping-pong bank index and reads one full frame of filtered depth from that bank.
//  It streams the frame out over a valid/ready interface, absorbing BRAM read latency and downstream backpressure.
//  It reports idle once the last pixel has been accepted downstream.

---
 rtl/out_bram_reader.sv | 162 ++++++++++++++++
 tb/tb_out_bram_reader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_bram_reader.sv
// Output-stage frame reader: on start, reads one frame from the selected BRAM bank and streams it
// over valid/ready. Optional sof/eol sideband is enabled by OUT_BRAM_READER_SOF_EOL_EN.
module out_bram_reader #(
    parameter int unsigned IMG_W      = 640,
    parameter int unsigned IMG_H      = 480,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned ADDR_W    = $clog2(IMG_W * IMG_H)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              index,
    output logic              idle,
    output logic              bram_rd_en,
    output logic              bram_rd_bank,
    output logic [ADDR_W-1:0] bram_rd_addr,
    input  logic [DATA_W-1:0] bram_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef OUT_BRAM_READER_SOF_EOL_EN
    output logic              out_sof,
    output logic              out_eol,
`endif
    output logic [DATA_W-1:0] out_data
);

    localparam int unsigned NPIX  = IMG_W * IMG_H;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
`ifdef OUT_BRAM_READER_SOF_EOL_EN
    localparam int unsigned FW = DATA_W + 2;
`else
    localparam int unsigned FW = DATA_W;
`endif

    typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

    state_e            state_q;
    logic              idle_q;
    logic              bank_q;
    logic [ADDR_W-1:0] addr_q;
    logic [RD_LAT-1:0] vld_q;
    logic [CNT_W-1:0]  inflight_q;
    logic [CNT_W-1:0]  count_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [FW-1:0]     mem_q [FIFO_DEPTH];

    logic          credit_ok;
    logic          rd_en;
    logic          push;
    logic          pop;
    logic [FW-1:0] push_word;

`ifdef OUT_BRAM_READER_SOF_EOL_EN
    logic [1:0] tag_q [RD_LAT];
    logic [1:0] issue_tag;
`endif

    // Credit covers every read that could still land in the FIFO, so a push never finds it full.
    always_comb begin
        credit_ok = ({1'b0, inflight_q} + {1'b0, count_q}) < (CNT_W + 1)'(FIFO_DEPTH);
        rd_en     = (state_q == StRead) && credit_ok;
        push      = vld_q[RD_LAT-1];
        pop       = (count_q != '0) && out_ready;
`ifdef OUT_BRAM_READER_SOF_EOL_EN
        issue_tag = {addr_q == '0, (32'(addr_q) % IMG_W) == (IMG_W - 1)};
        push_word = {tag_q[RD_LAT-1], bram_rd_data};
`else
        push_word = bram_rd_data;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            idle_q  <= 1'b1;
            bank_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        bank_q  <= index;
                        addr_q  <= '0;
                        state_q <= StRead;
                        idle_q  <= 1'b0;
                    end
                end
                StRead: begin
                    if (rd_en) begin
                        if (addr_q == LAST_ADDR) begin
                            state_q <= StDrain;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                        end
                    end
                end
                StDrain: begin
                    if (inflight_q == '0 && count_q == '0 && !pop) begin
                        state_q <= StIdle;
                        idle_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    idle_q  <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q      <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            vld_q      <= (vld_q << 1) | RD_LAT'(rd_en);
            inflight_q <= inflight_q + CNT_W'(rd_en) - CNT_W'(push);
            count_q    <= count_q + CNT_W'(push) - CNT_W'(pop);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q and the valid pipeline.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

`ifdef OUT_BRAM_READER_SOF_EOL_EN
    always_ff @(posedge clk) begin
        tag_q[0] <= issue_tag;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_q[i] <= tag_q[i-1];
        end
    end

    assign {out_sof, out_eol, out_data} = mem_q[rd_ptr_q];
`else
    assign out_data = mem_q[rd_ptr_q];
`endif

    assign idle         = idle_q;
    assign bram_rd_en   = rd_en;
    assign bram_rd_bank = bank_q;
    assign bram_rd_addr = addr_q;
    assign out_valid    = (count_q != '0);

endmodule

// File: tb/tb_out_bram_reader.sv
// Self-checking bench for out_bram_reader on an 8x4 frame with randomized backpressure.
// Sideband checks compile in when OUT_BRAM_READER_SOF_EOL_EN is defined.
module tb_out_bram_reader;

    localparam int unsigned IMG_W  = 8;
    localparam int unsigned IMG_H  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = $clog2(IMG_W * IMG_H);
    localparam int          NPIX   = IMG_W * IMG_H;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              index = 1'b0;
    logic              idle;
    logic              bram_rd_en;
    logic              bram_rd_bank;
    logic [ADDR_W-1:0] bram_rd_addr;
    logic [DATA_W-1:0] bram_rd_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
`ifdef OUT_BRAM_READER_SOF_EOL_EN
    logic              out_sof;
    logic              out_eol;
`endif

    out_bram_reader #(
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H),
        .DATA_W    (DATA_W),
        .RD_LAT    (RD_LAT),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .index       (index),
        .idle        (idle),
        .bram_rd_en  (bram_rd_en),
        .bram_rd_bank(bram_rd_bank),
        .bram_rd_addr(bram_rd_addr),
        .bram_rd_data(bram_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
`ifdef OUT_BRAM_READER_SOF_EOL_EN
        .out_sof     (out_sof),
        .out_eol     (out_eol),
`endif
        .out_data    (out_data)
    );

    always #5 clk = ~clk;

    // BRAM model: every cycle the addressed word {bank, addr} appears RD_LAT cycles later.
    logic [DATA_W-1:0] bram_pipe [RD_LAT];
    always @(posedge clk) begin
        bram_pipe[0] <= {bram_rd_bank, 7'(bram_rd_addr)};
        for (int i = 1; i < RD_LAT; i++) bram_pipe[i] <= bram_pipe[i-1];
    end
    assign bram_rd_data = bram_pipe[RD_LAT-1];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Ready driver: 0 always, 1 one-on/three-off, 2 random, 3 held low.
    int mode = 0;
    int ready_pct = 50;
    int phase = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            phase++;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (phase % 4 == 0);
                2: out_ready = ($urandom_range(0, 99) < ready_pct);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: observed stream and bookkeeping, cleared on request from the main process.
    int                clr_gen = 0;
    int                seen_gen = 0;
    int                cyc = 0;
    int                rd_cnt = 0;
    int                first_hs = 0;
    int                last_hs = 0;
    int                stall_err = 0;
    int                max_outst = 0;
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    logic [DATA_W-1:0] got_q [$];
    logic [1:0]        tag_q [$];

    always @(negedge clk) begin
        cyc++;
        if (seen_gen != clr_gen) begin
            seen_gen   = clr_gen;
            rd_cnt     = 0;
            stall_err  = 0;
            max_outst  = 0;
            prev_stall = 1'b0;
            got_q.delete();
            tag_q.delete();
        end
        if (!reset) begin
            if (bram_rd_en) rd_cnt++;
            if (prev_stall && (out_data !== prev_data || !out_valid)) stall_err++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (out_valid && out_ready) begin
                if (got_q.size() == 0) first_hs = cyc;
                last_hs = cyc;
                got_q.push_back(out_data);
`ifdef OUT_BRAM_READER_SOF_EOL_EN
                tag_q.push_back({out_sof, out_eol});
`else
                tag_q.push_back(2'b00);
`endif
            end
            if (rd_cnt - got_q.size() > max_outst) max_outst = rd_cnt - got_q.size();
        end
    end

    task automatic clear_stats();
        clr_gen++;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic start_frame(input logic idx);
        start = 1'b1;
        index = idx;
        @(posedge clk);
        #1;
        start = 1'b0;
        index = ~idx;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (idle) break;
        end
        check({tag, "_idle_done"}, 32'(idle), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Reference: pixel i of a bank-b frame is {b, i}; sof on pixel 0, eol at end of each line.
    task automatic check_frame(input string tag, input logic bank);
        logic [7:0] exp_px;
        check({tag, "_n_out"}, 32'(got_q.size()), NPIX);
        check({tag, "_n_rd"}, 32'(rd_cnt), NPIX);
        check({tag, "_stall_stable"}, 32'(stall_err), 0);
        check({tag, "_outst_le_depth"}, 32'(max_outst <= DEPTH), 1);
        for (int i = 0; i < got_q.size() && i < NPIX; i++) begin
            exp_px = {bank, 7'(i)};
            check($sformatf("%s_px%0d", tag, i), 32'(got_q[i]), 32'(exp_px));
`ifdef OUT_BRAM_READER_SOF_EOL_EN
            check($sformatf("%s_sof%0d", tag, i), 32'(tag_q[i][1]), 32'(i == 0));
            check($sformatf("%s_eol%0d", tag, i), 32'(tag_q[i][0]), 32'(i % IMG_W == IMG_W - 1));
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic bank;

        // 1) reset state, latency, full-rate frame from bank 1
        do_reset();
        check("rst_idle", 32'(idle), 1);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_rd_en", 32'(bram_rd_en), 0);
        check("rst_addr", 32'(bram_rd_addr), 0);
        check("rst_bank", 32'(bram_rd_bank), 0);
        mode = 0;
        clear_stats();
        start_frame(1'b1);
        check("t1_idle_low", 32'(idle), 0);
        repeat (2) @(posedge clk);
        #1;
        check("t1_valid_early", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        check("t1_valid_lat", 32'(out_valid), 1);
        wait_idle("t1", 200);
        check("t1_back_to_back", 32'(last_hs - first_hs), NPIX - 1);
        check_frame("t1", 1'b1);

        // 2) 1-on/3-off backpressure
        mode = 1;
        clear_stats();
        start_frame(1'b0);
        wait_idle("t2", 400);
        check_frame("t2", 1'b0);

        // 3) start mid-frame is ignored
        mode = 0;
        clear_stats();
        start_frame(1'b1);
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1;
        index = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle("t3a", 200);
        check_frame("t3a", 1'b1);
        clear_stats();
        start_frame(1'b0);
        wait_idle("t3b", 200);
        check_frame("t3b", 1'b0);

        // 4) reset after 5 outputs abandons the frame
        clear_stats();
        start_frame(1'b1);
        for (int i = 0; i < 100 && got_q.size() < 5; i++) begin
            @(posedge clk);
            #1;
        end
        check("t4_five_out", 32'(got_q.size() >= 5), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t4_rst_idle", 32'(idle), 1);
        check("t4_rst_valid", 32'(out_valid), 0);
        check("t4_rst_rd_en", 32'(bram_rd_en), 0);
        reset = 1'b0;
        clear_stats();
        start_frame(1'b0);
        wait_idle("t4", 200);
        check_frame("t4", 1'b0);

        // 5) downstream held off: reads stop at FIFO capacity
        mode = 3;
        clear_stats();
        start_frame(1'b1);
        repeat (20) @(posedge clk);
        #1;
        check("t5_rd_cnt", 32'(rd_cnt), DEPTH);
        check("t5_valid", 32'(out_valid), 1);
        check("t5_idle", 32'(idle), 0);
        mode = 0;
        wait_idle("t5", 200);
        check_frame("t5", 1'b1);

        // 7) random banks and random backpressure
        for (int f = 0; f < 4; f++) begin
            bank = 1'($urandom_range(0, 1));
            ready_pct = $urandom_range(20, 90);
            mode = 2;
            clear_stats();
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
            start_frame(bank);
            wait_idle($sformatf("r%0d", f), 1000);
            check_frame($sformatf("r%0d", f), bank);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
